// File: rtl/minisys_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : minisys_mem_stage_pkg
//  Purpose  : Shared definitions for the MEM pipeline stage: FSM state
//             encoding, store size codes, default ack timeout and the store
//             lane replication helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package minisys_mem_stage_pkg;

  // Bus handshake FSM: IDLE issues requests, WAIT holds them until ack/timeout.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Store size codes carried on memwriteM (also the unshifted byte enables).
  localparam logic [3:0] c_SIZE_NONE = 4'b0000;
  localparam logic [3:0] c_SIZE_BYTE = 4'b0001;
  localparam logic [3:0] c_SIZE_HALF = 4'b0011;
  localparam logic [3:0] c_SIZE_WORD = 4'b1111;

  localparam int c_ACK_TIMEOUT_DEFAULT = 15;

  // Replicate store data across all lanes so the byte enables alone pick
  // the destination bytes, whatever the address offset.
  function automatic logic [31:0] store_lanes(input logic [3:0]  size,
                                              input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      c_SIZE_BYTE: lanes = {4{data[7:0]}};
      c_SIZE_HALF: lanes = {2{data[15:0]}};
      default:     lanes = data;
    endcase
    return lanes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/minisys_mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : minisys_mem_stage_if
//  Purpose  : Data-memory bus between the MEM stage (master) and the data
//             memory (slave).
//  Signals  : dmem_req   request valid, held until dmem_ack
//             dmem_we    byte write enables (0000 = read)
//             dmem_addr  word-aligned byte address
//             dmem_wdata lane-replicated store data
//             dmem_rdata read data (valid with dmem_ack)
//             dmem_ack   transfer complete this cycle
//  Revision : 1.0 - initial release
// ============================================================================
interface minisys_mem_stage_if;
  logic        dmem_req;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/minisys_mem_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_load_align
//  Purpose  : Little-endian load lane extraction with sign/zero extension.
//  Ports    : i_rdata   32  raw word from data memory
//             i_addrLow  2  byte offset within the word
//             i_opLb/i_opLbu/i_opLh/i_opLhu/i_opLw  one-hot load type
//             o_data    32  extended load result
//  Revision : 1.0 - initial release
// ============================================================================
module mem_load_align (
  input  wire logic [31:0] i_rdata,
  input  wire logic [1:0]  i_addrLow,
  input  wire logic        i_opLb,
  input  wire logic        i_opLbu,
  input  wire logic        i_opLh,
  input  wire logic        i_opLhu,
  input  wire logic        i_opLw,
  output logic      [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addrLow)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  // Halfword loads are aligned, so only the upper offset bit picks the half.
  assign w_half = i_addrLow[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    if (i_opLw) begin
      o_data = i_rdata;
    end else if (i_opLb) begin
      o_data = {{24{w_byte[7]}}, w_byte};
    end else if (i_opLbu) begin
      o_data = {24'h000000, w_byte};
    end else if (i_opLh) begin
      o_data = {{16{w_half[15]}}, w_half};
    end else if (i_opLhu) begin
      o_data = {16'h0000, w_half};
    end
  end

endmodule
`default_nettype wire

// File: rtl/minisys_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : minisys_mem_stage
//  Purpose  : MEM pipeline stage with a request/ack data-memory bus, ack
//             timeout, alignment checking, load extension and MEM/WB register.
//  Ports    : clk, rst                    clock, async active-high reset
//             regwriteM/mem2regM/write_31M EX/MEM control
//             op_lbM..op_lwM              one-hot load type
//             memwriteM                   store size code
//             alu_outM/write_dataM/pcplus4M/write_regM  EX/MEM data
//             dmem                        data-memory bus (master side)
//             stallM                      freezes IF/ID/EX and EX/MEM
//             regwriteW/write_regW/result_to_writeW/align_excW/bus_errW  MEM/WB
//  Revision : 1.0 - initial release
// ============================================================================
module minisys_mem_stage
  import minisys_mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = c_ACK_TIMEOUT_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        regwriteM,
  input  wire logic        mem2regM,
  input  wire logic        write_31M,
  input  wire logic        op_lbM,
  input  wire logic        op_lbuM,
  input  wire logic        op_lhM,
  input  wire logic        op_lhuM,
  input  wire logic        op_lwM,
  input  wire logic [3:0]  memwriteM,
  input  wire logic [31:0] alu_outM,
  input  wire logic [31:0] write_dataM,
  input  wire logic [31:0] pcplus4M,
  input  wire logic [4:0]  write_regM,
  minisys_mem_stage_if.master dmem,
  output logic             stallM,
  output logic             regwriteW,
  output logic [4:0]       write_regW,
  output logic [31:0]      result_to_writeW,
  output logic             align_excW,
  output logic             bus_errW
);

  // Counter holds the number of cycles the current request has gone unacked,
  // including the first (IDLE) request cycle.
  localparam int                 c_CNT_W     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(ACK_TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  state_t               r_state, w_stateNext;
  logic [c_CNT_W-1:0]   r_cnt, w_cntNext;
  logic                 w_isLoad, w_isStore, w_misalign, w_access;
  logic                 w_reqRaw, w_req, w_timeout;
  logic [31:0]          w_loadData, w_result;

  logic                 r_regwriteW, r_alignExcW, r_busErrW;
  logic [4:0]           r_writeRegW;
  logic [31:0]          r_resultW;

  // ---------------------------------------------------------------- classify
  assign w_isLoad  = mem2regM;
  assign w_isStore = (memwriteM != c_SIZE_NONE);

  always_comb begin
    w_misalign = 1'b0;
    if (w_isLoad) begin
      if ((op_lhM || op_lhuM) && alu_outM[0])        w_misalign = 1'b1;
      if (op_lwM && (alu_outM[1:0] != 2'b00))         w_misalign = 1'b1;
    end
    if (w_isStore) begin
      if ((memwriteM == c_SIZE_WORD) && (alu_outM[1:0] != 2'b00)) w_misalign = 1'b1;
      if ((memwriteM == c_SIZE_HALF) && alu_outM[0])              w_misalign = 1'b1;
    end
  end

  assign w_access = (w_isLoad || w_isStore) && !w_misalign;

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_reqRaw    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_reqRaw = 1'b1;
          if (!dmem.dmem_ack) begin
            w_stateNext = ST_WAIT;
            w_cntNext   = c_CNT_ONE;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt >= c_CNT_LIMIT) begin
          // Give up: no request this cycle, so the stall releases and the
          // frozen instruction retires to WB flagged as a bus error.
          w_timeout   = 1'b1;
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end else begin
          w_reqRaw = 1'b1;
          if (dmem.dmem_ack) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + c_CNT_ONE;
          end
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- bus side
  // Address/data come straight from EX/MEM, which stallM holds frozen while
  // the request is outstanding, so they stay stable through WAIT.
  assign w_req           = w_reqRaw && !rst;
  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_addr  = {alu_outM[31:2], 2'b00};
  assign dmem.dmem_we    = w_req ? 4'(memwriteM << alu_outM[1:0]) : 4'b0000;
  assign dmem.dmem_wdata = store_lanes(memwriteM, write_dataM);
  assign stallM          = w_req && !dmem.dmem_ack;

  // -------------------------------------------------------------- load / WB
  mem_load_align u_loadAlign (
    .i_rdata   (dmem.dmem_rdata),
    .i_addrLow (alu_outM[1:0]),
    .i_opLb    (op_lbM),
    .i_opLbu   (op_lbuM),
    .i_opLh    (op_lhM),
    .i_opLhu   (op_lhuM),
    .i_opLw    (op_lwM),
    .o_data    (w_loadData)
  );

  assign w_result = mem2regM  ? w_loadData :
                    write_31M ? pcplus4M   : alu_outM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwriteW <= 1'b0;
      r_writeRegW <= 5'd0;
      r_resultW   <= 32'd0;
      r_alignExcW <= 1'b0;
      r_busErrW   <= 1'b0;
    end else if (stallM) begin
      // Bubble into WB while the memory access is outstanding.
      r_regwriteW <= 1'b0;
      r_writeRegW <= 5'd0;
      r_resultW   <= 32'd0;
      r_alignExcW <= 1'b0;
      r_busErrW   <= 1'b0;
    end else begin
      r_regwriteW <= regwriteM && !w_misalign && !w_timeout;
      r_writeRegW <= write_regM;
      r_resultW   <= w_result;
      r_alignExcW <= w_misalign;
      r_busErrW   <= w_timeout;
    end
  end

  assign regwriteW        = r_regwriteW;
  assign write_regW       = r_writeRegW;
  assign result_to_writeW = r_resultW;
  assign align_excW       = r_alignExcW;
  assign bus_errW         = r_busErrW;

endmodule
`default_nettype wire

// File: doc/minisys_mem_stage.md
MINISYS_MEM_STAGE -- requirements
Module: minisys_mem_stage

Interface
REQ-001 SHALL have parameter: ACK_TIMEOUT, default 15, maximum number of cycles a data-memory request waits for dmem_ack before aborting.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: regwriteM, mem2regM, write_31M  input  1 each  EX/MEM control bits.
REQ-005 SHALL have port: op_lbM, op_lbuM, op_lhM, op_lhuM, op_lwM  input  1 each  one-hot load type.
REQ-006 SHALL have port: memwriteM  input  4  store size code: 0001 byte, 0011 half, 1111 word, 0000 no store.
REQ-007 SHALL have port: alu_outM, write_dataM, pcplus4M  input  32 each  address/ALU result, store data, PC+4.
REQ-008 SHALL have port: write_regM  input  5  destination register.
REQ-009 SHALL have port: dmem_req  output  1; dmem_we  output  4; dmem_addr  output  32 (word-aligned); dmem_wdata  output  32.
REQ-010 SHALL have port: dmem_rdata  input  32; dmem_ack  input  1.
REQ-011 SHALL have port: stallM  output  1  freezes the IF/ID/EX stages and the EX/MEM register.
REQ-012 SHALL have port: regwriteW  output  1; write_regW  output  5; result_to_writeW  output  32; align_excW  output  1; bus_errW  output  1.

Function
REQ-013 SHALL classify an access as: load = mem2regM; store = memwriteM != 0; none otherwise.
REQ-014 SHALL flag misalignment when: lh/lhu with addr[0]=1; lw or word store with addr[1:0]!=0; half store with addr[0]=1. A misaligned access issues no request.
REQ-015 SHALL run FSM IDLE/WAIT. IDLE: aligned access -> dmem_req=1 the same cycle, go to WAIT unless dmem_ack=1 that cycle. WAIT: dmem_req held with stable addr/we/wdata until dmem_ack=1, then return to IDLE.
REQ-016 SHALL drive stallM=1 whenever dmem_req=1 and dmem_ack=0; stallM=0 in the ack cycle.
REQ-017 SHALL count cycles in WAIT. When the count reaches ACK_TIMEOUT: drop dmem_req, return to IDLE, release the stall, and pass the instruction to WB with bus_errW=1 and regwriteW=0.
REQ-018 SHALL generate dmem_we = size code shifted left by addr[1:0] for stores, 0000 for loads. dmem_wdata SHALL be byte-replicated for byte stores, halfword-replicated for half stores, and passed through for word stores.
REQ-019 SHALL extract load data little-endian, by addr[1:0]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
REQ-020 SHALL select the WB result as: loaded data if mem2regM; pcplus4M if write_31M; alu_outM otherwise.
REQ-021 SHALL register into MEM/WB on every non-stalled cycle. While stallM=1, the register SHALL load a bubble (regwriteW=0, align_excW=0, bus_errW=0).
REQ-022 SHALL force regwriteW=0 and set align_excW=1 for a misaligned instruction, with zero added stall cycles.
REQ-023 SHALL complete a zero-wait access (ack in the request cycle) with no stall and a total latency of one cycle to WB.

Reset
REQ-024 SHALL, on rst=1 (asynchronous): set FSM to IDLE, timeout counter to 0, and every MEM/WB output to 0. dmem_req=0 and stallM=0 while rst=1.
REQ-025 SHALL abandon any outstanding request on reset mid-WAIT; a late dmem_ack after reset SHALL be ignored.

Structure
REQ-026 SHALL place the state encoding, store size codes and the ACK_TIMEOUT default in a shared package.
REQ-027 SHALL implement load extraction/extension as one combinational sub-module: mem_load_align.

Verification
REQ-028 Bench SHALL check: lb addr=0x103, rdata=0x80FF_FF7F, ack same cycle -> result_to_writeW=0xFFFF_FF80, regwriteW=1, stallM never 1.
REQ-029 Bench SHALL check: sh addr=0x202, write_dataM=0x1234_ABCD -> dmem_we=1100, dmem_wdata=0xABCD_ABCD, dmem_addr=0x200.
REQ-030 Bench SHALL check: lhu addr=0x10, ack after 3 cycles, rdata=0x0000_9ABC -> stallM=1 for exactly 3 cycles, result 0x0000_9ABC.
REQ-031 Bench SHALL check: lw addr=0x6 -> no dmem_req, align_excW=1, regwriteW=0, no stall.
REQ-032 Bench SHALL check: lw with ack never asserted -> stall for 15 cycles, then bus_errW=1, regwriteW=0, dmem_req=0.
REQ-033 Bench SHALL check: rst pulse in cycle 2 of WAIT, then late ack -> all outputs 0, FSM IDLE, no WB write.
